// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: stage count of the reference build and the
// branch-tracking state of the stall/bubble controller.
package lc3b_types;

  localparam int LC3B_STAGES = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    RES_HELD = 2'd2
  } stall_state_t;

endpackage

// File: rtl/stall_prio_enc.sv
// Highest-set-bit encoder over the per-stage stall requests; also flags
// whether any stage is requesting a stall.
module stall_prio_enc #(
  parameter int NUM_STAGES = 5,
  parameter int HW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic [NUM_STAGES-1:0] req,
  output logic [HW-1:0]         hi,
  output logic                  any
);

  always_comb begin
    hi  = '0;
    any = |req;
    // Ascending scan so the last hit is the oldest (highest) stalling stage.
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (req[s]) hi = HW'(s);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall and bubble controller: freezes every register at or behind the oldest
// stalling stage, bubbles the one ahead of it, and tracks one in-flight branch.
module pipeline_stall_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  br_decoded,
  input  logic                  br_resolved,
  input  logic                  br_taken,
  output logic [NUM_STAGES-1:0] load,
  output logic [NUM_STAGES-1:0] valid,
  output logic                  pc_redirect,
  output logic                  br_pending,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  localparam int HW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [HW-1:0] hi;
  logic          freeze;
  stall_state_t  state;
  logic          taken_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  stall_prio_enc #(
    .NUM_STAGES(NUM_STAGES),
    .HW        (HW)
  ) u_enc (
    .req(stall_req),
    .hi (hi),
    .any(freeze)
  );

  assign br_pending = (state != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      taken_q      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (freeze) stall_cycles <= sat_inc(stall_cycles);
      case (state)
        RUN: begin
          if (br_decoded && !freeze) state <= BR_WAIT;
        end
        BR_WAIT: begin
          if (br_resolved) begin
            if (freeze) begin
              taken_q <= br_taken;
              state   <= RES_HELD;
            end else begin
              state <= RUN;
            end
          end
        end
        RES_HELD: begin
          if (!freeze) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    load        = '1;
    valid       = '1;
    pc_redirect = 1'b0;
    if (reset) begin
      // Flush: every register loads a bubble.
      valid = '0;
    end else if (freeze) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (s <= int'(hi))          load[s]  = 1'b0;
        else if (s == int'(hi) + 1) valid[s] = 1'b0;
      end
    end else begin
      case (state)
        BR_WAIT: begin
          // Every BR_WAIT cycle, including the resolving one, feeds decode a bubble.
          valid[1] = 1'b0;
          if (br_resolved) pc_redirect = br_taken;
          else             load[0]     = 1'b0;
        end
        RES_HELD: pc_redirect = taken_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (5 stages) with a scoreboard queue of
// expected outputs; a second instance with a 4-bit counter covers saturation.
module tb_pipeline_stall_ctrl;

  typedef struct {
    logic [4:0] load;
    logic [4:0] valid;
    logic       redir;
    int         pend;   // -1: not checked
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  stall_req;
  logic        br_decoded, br_resolved, br_taken;
  logic [4:0]  load, valid, load4, valid4;
  logic        pc_redirect, br_pending, pc_redirect4, br_pending4;
  logic [15:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   m_cnt16 = 0;
  int   m_cnt4  = 0;
  bit   m_known = 1'b0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.NUM_STAGES(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req),
    .br_decoded(br_decoded), .br_resolved(br_resolved), .br_taken(br_taken),
    .load(load), .valid(valid), .pc_redirect(pc_redirect),
    .br_pending(br_pending), .stall_cycles(stall_cycles)
  );

  pipeline_stall_ctrl #(.NUM_STAGES(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .stall_req(stall_req),
    .br_decoded(br_decoded), .br_resolved(br_resolved), .br_taken(br_taken),
    .load(load4), .valid(valid4), .pc_redirect(pc_redirect4),
    .br_pending(br_pending4), .stall_cycles(stall_cycles4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, push expectation, compare, then clock.
  task automatic step(input string tag, input logic rst, input logic [4:0] sr,
                      input logic dec, input logic res, input logic tk,
                      input logic [4:0] eload, input logic [4:0] evalid,
                      input logic eredir, input int epend);
    exp_t e;
    @(negedge clk);
    reset = rst; stall_req = sr; br_decoded = dec; br_resolved = res; br_taken = tk;
    e.load = eload; e.valid = evalid; e.redir = eredir; e.pend = epend;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({tag, ".load"},  32'(load),        32'(e.load));
    chk({tag, ".valid"}, 32'(valid),       32'(e.valid));
    chk({tag, ".redir"}, 32'(pc_redirect), 32'(e.redir));
    if (e.pend >= 0) chk({tag, ".pend"}, 32'(br_pending), 32'(e.pend));
    if (m_known) begin
      chk({tag, ".cnt16"}, 32'(stall_cycles),  32'(m_cnt16));
      chk({tag, ".cnt4"},  32'(stall_cycles4), 32'(m_cnt4));
    end
    @(posedge clk);
    if (rst) begin
      m_cnt16 = 0; m_cnt4 = 0; m_known = 1'b1;
    end else if (sr != 5'b0) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15)     m_cnt4++;
    end
  endtask

  initial begin
    reset = 1'b1; stall_req = '0; br_decoded = 0; br_resolved = 0; br_taken = 0;

    // Reset flush with a stall request present
    step("rst0", 1, 5'b01000, 0, 0, 0, 5'b11111, 5'b00000, 0, -1);
    step("rst1", 1, 5'b01000, 0, 0, 0, 5'b11111, 5'b00000, 0, 0);
    step("idle", 0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);

    // Decode stall, counter advancing
    for (int i = 0; i < 3; i++)
      step("dec_stall", 0, 5'b00010, 0, 0, 0, 5'b11100, 5'b11011, 0, 0);
    step("multi",  0, 5'b01010, 0, 0, 0, 5'b10000, 5'b01111, 0, 0);
    step("top",    0, 5'b10000, 0, 0, 0, 5'b00000, 5'b11111, 0, 0);
    step("icache", 0, 5'b00001, 0, 0, 0, 5'b11110, 5'b11101, 0, 0);

    // Taken branch
    step("bt_dec",  0, 5'b00000, 1, 0, 0, 5'b11111, 5'b11111, 0, 0);
    step("bt_wait", 0, 5'b00000, 0, 0, 0, 5'b11110, 5'b11101, 0, 1);
    step("bt_wait", 0, 5'b00000, 0, 0, 0, 5'b11110, 5'b11101, 0, 1);
    step("bt_res",  0, 5'b00000, 0, 1, 1, 5'b11111, 5'b11101, 1, 1);
    step("bt_run",  0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);

    // Not-taken branch
    step("bn_dec",  0, 5'b00000, 1, 0, 0, 5'b11111, 5'b11111, 0, 0);
    step("bn_wait", 0, 5'b00000, 0, 0, 0, 5'b11110, 5'b11101, 0, 1);
    step("bn_res",  0, 5'b00000, 0, 1, 0, 5'b11111, 5'b11101, 0, 1);
    step("bn_run",  0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);

    // Resolution during a dcache freeze is held until the freeze drops
    step("bh_dec",  0, 5'b00000, 1, 0, 0, 5'b11111, 5'b11111, 0, 0);
    step("bh_wait", 0, 5'b00000, 0, 0, 0, 5'b11110, 5'b11101, 0, 1);
    step("bh_res",  0, 5'b01000, 0, 1, 1, 5'b10000, 5'b01111, 0, 1);
    step("bh_hold", 0, 5'b01000, 0, 0, 0, 5'b10000, 5'b01111, 0, 1);
    step("bh_hold", 0, 5'b01000, 0, 0, 0, 5'b10000, 5'b01111, 0, 1);
    step("bh_rel",  0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 1, 1);
    step("bh_run",  0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);

    // Ignored events: resolve in RUN, decode during freeze
    step("ign_res", 0, 5'b00000, 0, 1, 1, 5'b11111, 5'b11111, 0, 0);
    step("ign_dec", 0, 5'b00100, 1, 0, 0, 5'b11000, 5'b10111, 0, 0);
    step("ign_chk", 0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);

    // Reset while a resolution is held discards the redirect
    step("rh_dec",  0, 5'b00000, 1, 0, 0, 5'b11111, 5'b11111, 0, 0);
    step("rh_wait", 0, 5'b00000, 0, 0, 0, 5'b11110, 5'b11101, 0, 1);
    step("rh_res",  0, 5'b01000, 0, 1, 1, 5'b10000, 5'b01111, 0, 1);
    step("rh_rst",  1, 5'b01000, 0, 0, 0, 5'b11111, 5'b00000, 0, 1);
    step("rh_after",0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++)
      step("sat", 0, 5'b10000, 0, 0, 0, 5'b00000, 5'b11111, 0, 0);
    step("sat_hold", 0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);
    chk("sat_val", 32'(stall_cycles4), 32'd15);
    step("sat_hold", 0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);
    step("sat_rst",  1, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 0, 0);
    step("sat_clr",  0, 5'b00000, 0, 0, 0, 5'b11111, 5'b11111, 0, 0);
    chk("clr_val", 32'(stall_cycles4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Parametrised stall and bubble controller for the LC-3b pipeline. It generalises fixed per-stage decode stall handling to any number of stages. It freezes every register at or behind the oldest stalling stage and injects a bubble just ahead of it. It also tracks in-flight branches with a small state machine, and a saturating counter accumulates freeze cycles for performance measurement.

## Interface
Parameters:
- NUM_STAGES, 5, number of pipeline registers. Register 0 is the PC and register s feeds stage s. Minimum 3.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall_req  in  NUM_STAGES  bit s set means stage s cannot complete this cycle (icache miss = bit 0, decode dependency = bit 1, dcache miss = bit 3 in the 5-stage build).
- br_decoded  in  1  control-flow instruction in stage 1; held by the datapath until it advances.
- br_resolved  in  1  branch outcome known this cycle (single-cycle pulse).
- br_taken  in  1  qualifies br_resolved.
- load  out  NUM_STAGES  load enable for register s.
- valid  out  NUM_STAGES  bubble mask; 0 forces the valid bit written into register s to 0, and 1 passes the upstream valid.
- pc_redirect  out  1  PC mux selects the branch target this cycle.
- br_pending  out  1  branch in flight (state not RUN).
- stall_cycles  out  CNT_WIDTH  saturating count of freeze cycles.

## Operation
- h is the highest index with stall_req[h]=1. "Freeze" means any bit is set.
- Freeze mapping:
  - s ≤ h: load=0, valid=1.
  - s = h+1 (when h+1 < NUM_STAGES): load=1, valid=0.
  - s > h+1: load=1, valid=1.
- No freeze: all load=1 and valid=1, subject to the branch overrides below.
- The freeze has priority over every branch override.
- FSM states (stall_state_t): RUN, BR_WAIT, RES_HELD.
  - RUN: if br_decoded and no freeze, go to BR_WAIT. br_decoded during a freeze is ignored.
  - BR_WAIT:
    - With no freeze: load[0]=0 (PC holds), and load[1]=1 with valid[1]=0 (bubbles into decode).
    - On br_resolved with no freeze: load[0]=1, pc_redirect=br_taken, and the state goes to RUN in the same cycle.
    - On br_resolved during a freeze: latch br_taken and go to RES_HELD.
  - RES_HELD: outputs follow the freeze. On the first cycle with no freeze: load[0]=1, pc_redirect equals the latched taken bit, and the state goes to RUN.
- pc_redirect is asserted only as described above and is never asserted in RUN.
- br_resolved in RUN is ignored.
- stall_cycles increments by 1 on each freeze cycle and holds at all-ones.

## Timing
- load, valid and pc_redirect are combinational from the inputs and the current state. There are zero cycles of latency from stall_req to load.
- State and counter update on the rising clk edge.
- The branch penalty is one bubble per BR_WAIT cycle. Resolution can occur no earlier than the cycle after br_decoded is accepted.
- Reset values:
  - state RUN, br_pending=0, pc_redirect=0, stall_cycles=0, latched taken bit=0.
  - While reset is high, load is all ones and valid is all zeros, which flushes the pipe with bubbles.
- Reset mid-branch or mid-RES_HELD discards the pending redirect.
- Simultaneous events:
  - br_decoded together with br_resolved in BR_WAIT is not legal. Only one branch is in flight at a time.
  - A freeze with h = NUM_STAGES-1 produces no bubble; everything holds.

## Structure
- stall_state_t enum goes in lc3b_types, next to existing pipeline types.
- Sub-module stall_prio_enc: parametrised highest-set-bit encoder producing h and an any-stall flag.
- A single always_ff block handles state, the latched taken bit and the counter; a single always_comb block produces load, valid and pc_redirect.

## Test plan
All scenarios use NUM_STAGES=5; bit vectors are written [4:0].
- Reset held 2 cycles with stall_req=01000 → load=11111, valid=00000; after release stall_cycles=0 and br_pending=0.
- stall_req=00010 → load=11100, valid=11011; stall_cycles increments once per cycle.
- stall_req=01010 → load=10000, valid=01111. stall_req=10000 → load=00000.
- br_decoded with no stall → next cycle br_pending=1, load[0]=0, valid[1]=0 until br_resolved=1 with br_taken=1, which gives pc_redirect=1 and load[0]=1 that cycle, then RUN. Repeat with br_taken=0: pc_redirect=0.
- In BR_WAIT, br_resolved with br_taken=1 while stall_req=01000 for 3 cycles → pc_redirect stays 0 and br_pending=1. In the cycle the stall drops, pc_redirect=1 for exactly 1 cycle.
- CNT_WIDTH=4 with 20 consecutive freeze cycles → stall_cycles=15, and it holds 15 afterwards. Reset returns it to 0.
